// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage_pkg
//  Description : Shared constants, defaults and the stage-action decode used
//                by the MEM/WB pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_wb_stage_pkg;

    // Shared pipeline defines
    localparam logic        RstEnable    = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;

    // Default widths
    localparam int c_DEF_DW = 32;
    localparam int c_DEF_AW = 5;

    // What the stage register does on the next edge (reset handled separately)
    typedef enum logic [1:0] {
        ACT_CAPTURE = 2'd0,
        ACT_HOLD    = 2'd1,
        ACT_BUBBLE  = 2'd2,
        ACT_FLUSH   = 2'd3
    } stage_act_e;

    // Priority: flush > bubble > hold > capture. The illegal combination
    // (MEM running into a stalled WB) resolves to hold.
    function automatic stage_act_e decode_act(input logic flush,
                                              input logic stall_mem,
                                              input logic stall_wb);
        stage_act_e act;
        if (flush)
            act = ACT_FLUSH;
        else if (stall_mem && !stall_wb)
            act = ACT_BUBBLE;
        else if (stall_wb)
            act = ACT_HOLD;
        else
            act = ACT_CAPTURE;
        return act;
    endfunction

endpackage : mem_wb_stage_pkg
`default_nettype wire

// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage_if
//  Description : MEM/WB stage bus: pipeline control, MEM-side payload and the
//                registered WB-side outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_wb_stage_if #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NCH = 2,
    parameter int CW  = 16
);
    // Control
    logic                stall_mem;
    logic                stall_wb;
    logic                flush;
    logic                cnt_clr;
    // MEM side
    logic                mem_valid;
    logic [NCH*AW-1:0]   mem_wd;
    logic [NCH-1:0]      mem_wreg;
    logic [NCH*DW-1:0]   mem_wdata;
    logic [DW-1:0]       mem_hi;
    logic [DW-1:0]       mem_lo;
    logic                mem_whilo;
    logic                mem_llbit_we;
    logic                mem_llbit_value;
    logic                mem_cp0_we;
    logic [4:0]          mem_cp0_waddr;
    logic [DW-1:0]       mem_cp0_wdata;
    // WB side
    logic                wb_valid;
    logic [NCH*AW-1:0]   wb_wd;
    logic [NCH-1:0]      wb_wreg;
    logic [NCH*DW-1:0]   wb_wdata;
    logic [DW-1:0]       wb_hi;
    logic [DW-1:0]       wb_lo;
    logic                wb_whilo;
    logic                wb_llbit_we;
    logic                wb_llbit_value;
    logic                wb_cp0_we;
    logic [4:0]          wb_cp0_waddr;
    logic [DW-1:0]       wb_cp0_wdata;
    logic [CW-1:0]       bubble_cnt;
    logic                stall_err;

    // Upstream/controller side
    modport master (
        output stall_mem, stall_wb, flush, cnt_clr,
        output mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo,
        output mem_whilo, mem_llbit_we, mem_llbit_value,
        output mem_cp0_we, mem_cp0_waddr, mem_cp0_wdata,
        input  wb_valid, wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo,
        input  wb_llbit_we, wb_llbit_value, wb_cp0_we, wb_cp0_waddr,
        input  wb_cp0_wdata, bubble_cnt, stall_err
    );

    // Stage register side
    modport slave (
        input  stall_mem, stall_wb, flush, cnt_clr,
        input  mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo,
        input  mem_whilo, mem_llbit_we, mem_llbit_value,
        input  mem_cp0_we, mem_cp0_waddr, mem_cp0_wdata,
        output wb_valid, wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo,
        output wb_llbit_we, wb_llbit_value, wb_cp0_we, wb_cp0_waddr,
        output wb_cp0_wdata, bubble_cnt, stall_err
    );

endinterface : mem_wb_stage_if
`default_nettype wire

// File: rtl/mem_wb_stage_wb_lane_reg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_lane_reg
//  Description : One register-writeback lane of the MEM/WB stage: holds
//                wd/wreg/wdata with bubble / capture / hold selection.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_lane_reg
    import mem_wb_stage_pkg::*;
#(
    parameter int DW = c_DEF_DW,
    parameter int AW = c_DEF_AW
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_bubble,   // load the bubble value (flush or bubble)
    input  wire logic          i_capture,  // load the incoming lane
    input  wire logic [AW-1:0] i_wd,
    input  wire logic          i_wreg,     // already qualified by valid and dedup
    input  wire logic [DW-1:0] i_wdata,
    output logic      [AW-1:0] o_wd,
    output logic               o_wreg,
    output logic      [DW-1:0] o_wdata
);

    logic [AW-1:0] r_wd;
    logic          r_wreg;
    logic [DW-1:0] r_wdata;

    // Lane register: reset > bubble > capture, otherwise hold
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_wd    <= '0;
            r_wreg  <= WriteDisable;
            r_wdata <= '0;
        end else if (i_bubble) begin
            r_wd    <= '0;
            r_wreg  <= WriteDisable;
            r_wdata <= '0;
        end else if (i_capture) begin
            r_wd    <= i_wd;
            r_wreg  <= i_wreg;
            r_wdata <= i_wdata;
        end
    end

    assign o_wd    = r_wd;
    assign o_wreg  = r_wreg;
    assign o_wdata = r_wdata;

endmodule : wb_lane_reg
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage
//  Description : MEM/WB pipeline register with flush/bubble/hold control,
//                same-destination lane dedup, saturating bubble counter and
//                a sticky illegal-stall flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DW  = c_DEF_DW,
    parameter int AW  = c_DEF_AW,
    parameter int NCH = 2,
    parameter int CW  = 16
) (
    input  wire logic      clk,
    input  wire logic      rst,
    mem_wb_stage_if.slave  bus
);

    stage_act_e        w_act;
    logic              w_bubble;
    logic              w_capture;
    logic              w_illegal;
    logic [NCH-1:0]    w_wreg_cap;
    logic [NCH*AW-1:0] w_lane_wd;
    logic [NCH-1:0]    w_lane_wreg;
    logic [NCH*DW-1:0] w_lane_wdata;

    logic              r_valid;
    logic [DW-1:0]     r_hi;
    logic [DW-1:0]     r_lo;
    logic              r_whilo;
    logic              r_llbit_we;
    logic              r_llbit_value;
    logic              r_cp0_we;
    logic [4:0]        r_cp0_waddr;
    logic [DW-1:0]     r_cp0_wdata;
    logic [CW-1:0]     r_bubble_cnt;
    logic              r_stall_err;

    assign w_act     = decode_act(bus.flush, bus.stall_mem, bus.stall_wb);
    assign w_bubble  = (w_act == ACT_FLUSH) || (w_act == ACT_BUBBLE);
    assign w_capture = (w_act == ACT_CAPTURE);
    assign w_illegal = !bus.stall_mem && bus.stall_wb;

    // Qualify lane enables by valid; a lower lane loses to any higher lane
    // writing the same register (address 0 included)
    always_comb begin
        w_wreg_cap = '0;
        for (int i = 0; i < NCH; i++) begin
            w_wreg_cap[i] = bus.mem_wreg[i] & bus.mem_valid;
            for (int j = i + 1; j < NCH; j++) begin
                if (bus.mem_wreg[j] &&
                    (bus.mem_wd[j*AW +: AW] == bus.mem_wd[i*AW +: AW]))
                    w_wreg_cap[i] = 1'b0;
            end
        end
    end

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_lane
            wb_lane_reg #(
                .DW (DW),
                .AW (AW)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .i_bubble  (w_bubble),
                .i_capture (w_capture),
                .i_wd      (bus.mem_wd[g*AW +: AW]),
                .i_wreg    (w_wreg_cap[g]),
                .i_wdata   (bus.mem_wdata[g*DW +: DW]),
                .o_wd      (w_lane_wd[g*AW +: AW]),
                .o_wreg    (w_lane_wreg[g]),
                .o_wdata   (w_lane_wdata[g*DW +: DW])
            );
        end
    endgenerate

    // Shared HI/LO, LL-bit and CP0 fields plus the valid flag
    always_ff @(posedge clk) begin
        if (rst == RstEnable || w_bubble) begin
            r_valid       <= 1'b0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_whilo       <= WriteDisable;
            r_llbit_we    <= WriteDisable;
            r_llbit_value <= 1'b0;
            r_cp0_we      <= WriteDisable;
            r_cp0_waddr   <= '0;
            r_cp0_wdata   <= '0;
        end else if (w_capture) begin
            r_valid       <= bus.mem_valid;
            r_hi          <= bus.mem_hi;
            r_lo          <= bus.mem_lo;
            r_whilo       <= bus.mem_whilo & bus.mem_valid;
            r_llbit_we    <= bus.mem_llbit_we & bus.mem_valid;
            r_llbit_value <= bus.mem_llbit_value;
            r_cp0_we      <= bus.mem_cp0_we & bus.mem_valid;
            r_cp0_waddr   <= bus.mem_cp0_waddr;
            r_cp0_wdata   <= bus.mem_cp0_wdata;
        end
    end

    // Saturating bubble counter; clear beats a same-edge increment
    always_ff @(posedge clk) begin
        if (rst == RstEnable || bus.cnt_clr)
            r_bubble_cnt <= '0;
        else if (w_bubble && !(&r_bubble_cnt))
            r_bubble_cnt <= r_bubble_cnt + CW'(1);
    end

    // Sticky flag for MEM advancing into a stalled WB
    always_ff @(posedge clk) begin
        if (rst == RstEnable)
            r_stall_err <= 1'b0;
        else if (w_illegal)
            r_stall_err <= 1'b1;
    end

    assign bus.wb_valid       = r_valid;
    assign bus.wb_wd          = w_lane_wd;
    assign bus.wb_wreg        = w_lane_wreg;
    assign bus.wb_wdata       = w_lane_wdata;
    assign bus.wb_hi          = r_hi;
    assign bus.wb_lo          = r_lo;
    assign bus.wb_whilo       = r_whilo;
    assign bus.wb_llbit_we    = r_llbit_we;
    assign bus.wb_llbit_value = r_llbit_value;
    assign bus.wb_cp0_we      = r_cp0_we;
    assign bus.wb_cp0_waddr   = r_cp0_waddr;
    assign bus.wb_cp0_wdata   = r_cp0_wdata;
    assign bus.bubble_cnt     = r_bubble_cnt;
    assign bus.stall_err      = r_stall_err;

endmodule : mem_wb_stage
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wb_stage
//  Description : Self-checking bench for mem_wb_stage (NCH=2, CW=4): directed
//                scenarios followed by randomized traffic, all checked against
//                a behavioural model of the stage rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NCH = 2;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_wb_stage_if #(.DW(DW), .AW(AW), .NCH(NCH), .CW(CW)) bus ();

    mem_wb_stage #(.DW(DW), .AW(AW), .NCH(NCH), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Expected state
    logic              e_valid;
    logic [NCH*AW-1:0] e_wd;
    logic [NCH-1:0]    e_wreg;
    logic [NCH*DW-1:0] e_wdata;
    logic [DW-1:0]     e_hi, e_lo, e_cp0d;
    logic              e_whilo, e_llwe, e_llv, e_cp0we, e_err;
    logic [4:0]        e_cp0a;
    int                e_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_zero_outputs();
        e_valid = 0; e_wd = '0; e_wreg = '0; e_wdata = '0;
        e_hi = '0; e_lo = '0; e_whilo = 0; e_llwe = 0; e_llv = 0;
        e_cp0we = 0; e_cp0a = '0; e_cp0d = '0;
    endtask

    // Behavioural model of one clock edge, from the current inputs
    task automatic model_edge();
        bit claimed [1 << AW];
        if (rst) begin
            model_zero_outputs();
            e_cnt = 0;
            e_err = 0;
        end else begin
            if (!bus.stall_mem && bus.stall_wb) e_err = 1;
            if (bus.flush || (bus.stall_mem && !bus.stall_wb)) begin
                model_zero_outputs();
                if (bus.cnt_clr) e_cnt = 0;
                else if (e_cnt < CMAX) e_cnt = e_cnt + 1;
            end else begin
                if (bus.cnt_clr) e_cnt = 0;
                if (!bus.stall_mem && !bus.stall_wb) begin
                    e_valid = bus.mem_valid;
                    e_wd    = bus.mem_wd;
                    e_wdata = bus.mem_wdata;
                    e_wreg  = '0;
                    foreach (claimed[k]) claimed[k] = 0;
                    // highest lane claims an address first
                    for (int i = NCH - 1; i >= 0; i--) begin
                        int a;
                        a = int'(bus.mem_wd[i*AW +: AW]);
                        if (bus.mem_valid && bus.mem_wreg[i]) begin
                            if (!claimed[a]) e_wreg[i] = 1'b1;
                            claimed[a] = 1;
                        end
                    end
                    e_hi    = bus.mem_hi;
                    e_lo    = bus.mem_lo;
                    e_whilo = bus.mem_whilo & bus.mem_valid;
                    e_llwe  = bus.mem_llbit_we & bus.mem_valid;
                    e_llv   = bus.mem_llbit_value;
                    e_cp0we = bus.mem_cp0_we & bus.mem_valid;
                    e_cp0a  = bus.mem_cp0_waddr;
                    e_cp0d  = bus.mem_cp0_wdata;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("wb_valid",   64'(bus.wb_valid),       64'(e_valid));
        chk("wb_wd",      64'(bus.wb_wd),          64'(e_wd));
        chk("wb_wreg",    64'(bus.wb_wreg),        64'(e_wreg));
        chk("wb_wdata",   64'(bus.wb_wdata),       64'(e_wdata));
        chk("wb_hi",      64'(bus.wb_hi),          64'(e_hi));
        chk("wb_lo",      64'(bus.wb_lo),          64'(e_lo));
        chk("wb_whilo",   64'(bus.wb_whilo),       64'(e_whilo));
        chk("wb_llwe",    64'(bus.wb_llbit_we),    64'(e_llwe));
        chk("wb_llval",   64'(bus.wb_llbit_value), 64'(e_llv));
        chk("wb_cp0we",   64'(bus.wb_cp0_we),      64'(e_cp0we));
        chk("wb_cp0a",    64'(bus.wb_cp0_waddr),   64'(e_cp0a));
        chk("wb_cp0d",    64'(bus.wb_cp0_wdata),   64'(e_cp0d));
        chk("bubble_cnt", 64'(bus.bubble_cnt),     64'(e_cnt));
        chk("stall_err",  64'(bus.stall_err),      64'(e_err));
    endtask

    // Advance one edge, then compare every output against the model
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive_idle();
        bus.stall_mem = 0; bus.stall_wb = 0; bus.flush = 0; bus.cnt_clr = 0;
        bus.mem_valid = 0; bus.mem_wd = '0; bus.mem_wreg = '0; bus.mem_wdata = '0;
        bus.mem_hi = '0; bus.mem_lo = '0; bus.mem_whilo = 0;
        bus.mem_llbit_we = 0; bus.mem_llbit_value = 0;
        bus.mem_cp0_we = 0; bus.mem_cp0_waddr = '0; bus.mem_cp0_wdata = '0;
    endtask

    task automatic drive_random_payload();
        bus.mem_valid       = ($urandom_range(0, 3) != 0);
        bus.mem_wd          = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
        bus.mem_wreg        = NCH'($urandom);
        bus.mem_wdata       = {$urandom, $urandom};
        bus.mem_hi          = $urandom;
        bus.mem_lo          = $urandom;
        bus.mem_whilo       = 1'($urandom);
        bus.mem_llbit_we    = 1'($urandom);
        bus.mem_llbit_value = 1'($urandom);
        bus.mem_cp0_we      = 1'($urandom);
        bus.mem_cp0_waddr   = 5'($urandom);
        bus.mem_cp0_wdata   = $urandom;
    endtask

    logic [NCH*DW-1:0] held_wdata;

    initial begin
        e_cnt = 0; e_err = 0;
        model_zero_outputs();
        drive_idle();
        rst = 1;

        // Reset, even with flush/clear/valid payload present
        bus.flush = 1; bus.cnt_clr = 1; bus.mem_valid = 1; bus.mem_wreg = 2'b11;
        tick();
        tick();
        chk("reset_cnt", 64'(bus.bubble_cnt), 64'd0);
        chk("reset_err", 64'(bus.stall_err), 64'd0);
        chk("reset_valid", 64'(bus.wb_valid), 64'd0);

        // First capture, both lanes distinct
        drive_idle();
        rst = 0;
        bus.mem_valid = 1;
        bus.mem_wd    = {5'd7, 5'd3};
        bus.mem_wreg  = 2'b11;
        bus.mem_wdata = {32'h0000_ABCD, 32'h0000_1234};
        tick();
        chk("cap_wdata", 64'(bus.wb_wdata), {32'h0000_ABCD, 32'h0000_1234});
        chk("cap_wreg",  64'(bus.wb_wreg), 64'd3);
        chk("cap_valid", 64'(bus.wb_valid), 64'd1);

        // Hold for three cycles with changing inputs, then bubble
        bus.stall_mem = 1; bus.stall_wb = 1;
        for (int k = 0; k < 3; k++) begin
            drive_random_payload();
            tick();
        end
        chk("hold_wdata", 64'(bus.wb_wdata), {32'h0000_ABCD, 32'h0000_1234});
        bus.stall_wb = 0;
        tick();
        chk("bubble_wreg", 64'(bus.wb_wreg), 64'd0);
        chk("bubble_cnt1", 64'(bus.bubble_cnt), 64'd1);

        // Dedup: both lanes target r9
        drive_idle();
        bus.mem_valid = 1; bus.mem_wd = {5'd9, 5'd9}; bus.mem_wreg = 2'b11;
        bus.mem_wdata = {32'h22, 32'h11};
        tick();
        chk("dedup_wreg", 64'(bus.wb_wreg), 64'b10);
        chk("dedup_l1",   64'(bus.wb_wdata[DW +: DW]), 64'h22);

        // Dedup on r0 too
        bus.mem_wd = {5'd0, 5'd0};
        tick();
        chk("dedup_r0", 64'(bus.wb_wreg), 64'b10);

        // Flush while holding, with HI/LO write pending
        bus.mem_whilo = 1; bus.stall_mem = 1; bus.stall_wb = 1; bus.flush = 1;
        tick();
        chk("flush_whilo", 64'(bus.wb_whilo), 64'd0);
        chk("flush_valid", 64'(bus.wb_valid), 64'd0);
        chk("flush_cnt",   64'(bus.bubble_cnt), 64'd2);

        // Invalid capture keeps data but drops enables
        drive_idle();
        bus.mem_valid = 0; bus.mem_wreg = 2'b11; bus.mem_cp0_we = 1;
        bus.mem_whilo = 1; bus.mem_llbit_we = 1;
        bus.mem_wd = {5'd4, 5'd5}; bus.mem_wdata = {32'hCAFE_0001, 32'hBEEF_0002};
        tick();
        chk("inv_wreg",  64'(bus.wb_wreg), 64'd0);
        chk("inv_cp0we", 64'(bus.wb_cp0_we), 64'd0);
        chk("inv_wdata", 64'(bus.wb_wdata), {32'hCAFE_0001, 32'hBEEF_0002});

        // Saturation, then clear beating a bubble
        drive_idle();
        bus.stall_mem = 1;
        for (int k = 0; k < 20; k++) tick();
        chk("sat_cnt", 64'(bus.bubble_cnt), 64'd15);
        bus.cnt_clr = 1;
        tick();
        chk("clr_cnt", 64'(bus.bubble_cnt), 64'd0);

        // Illegal stall: held outputs, sticky error
        drive_idle();
        bus.mem_valid = 1; bus.mem_wreg = 2'b01; bus.mem_wdata = {32'h5, 32'h6};
        tick();
        held_wdata = bus.wb_wdata;
        bus.stall_wb = 1; bus.mem_wdata = {32'h7, 32'h8};
        tick();
        chk("ill_err",  64'(bus.stall_err), 64'd1);
        chk("ill_hold", 64'(bus.wb_wdata), 64'(held_wdata));
        bus.stall_wb = 0;
        tick();
        chk("ill_sticky", 64'(bus.stall_err), 64'd1);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            drive_random_payload();
            rst           = ($urandom_range(0, 49) == 0);
            bus.flush     = ($urandom_range(0, 9) == 0);
            bus.cnt_clr   = ($urandom_range(0, 19) == 0);
            bus.stall_mem = ($urandom_range(0, 3) == 0);
            bus.stall_wb  = bus.stall_mem ? 1'($urandom) : ($urandom_range(0, 29) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mem_wb_stage
`default_nettype wire

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameters SHALL be:
- DW, 32, data width.
- AW, 5, register-address width.
- NCH, 2, number of register-writeback lanes (1..4).
- CW, 16, bubble-counter width.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- stall_mem  in  1  MEM stage stalled
- stall_wb  in  1  WB stage stalled
- flush  in  1  exception/pipeline flush
- cnt_clr  in  1  clear bubble counter
- mem_valid  in  1  MEM slot holds a real instruction
- mem_wd  in  NCH*AW  per-lane destination register, lane i at bits [i*AW +: AW]
- mem_wreg  in  NCH  per-lane register write enable
- mem_wdata  in  NCH*DW  per-lane write data
- mem_hi, mem_lo  in  DW each  HI/LO values
- mem_whilo  in  1  HI/LO write enable
- mem_llbit_we, mem_llbit_value  in  1 each  LL bit update
- mem_cp0_we  in  1  CP0 write enable
- mem_cp0_waddr  in  5  CP0 address
- mem_cp0_wdata  in  DW  CP0 data
- wb_valid  out  1  registered copy of mem_valid
- wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo, wb_llbit_we, wb_llbit_value, wb_cp0_we, wb_cp0_waddr, wb_cp0_wdata  out  same widths  registered copies of the mem_* inputs
- bubble_cnt  out  CW  saturating count of inserted bubbles
- stall_err  out  1  sticky illegal-stall flag

Function
REQ-004 All outputs SHALL be registered, with 1-cycle latency from the mem_* inputs to the wb_* outputs.
REQ-005 Update priority, evaluated at each rising clk edge, SHALL be: rst > flush > bubble > hold > capture.
REQ-006 On flush=1, all wb_* outputs SHALL be set to the bubble value: every enable 0, wb_wd = 0, all data fields 0, wb_valid = 0.
REQ-007 When stall_mem=1 and stall_wb=0 (bubble), the outputs SHALL be loaded with the bubble value.
REQ-008 When stall_mem=1 and stall_wb=1 (hold), all wb_* outputs SHALL keep their values.
REQ-009 When stall_mem=0 and stall_wb=1, the condition is illegal: the outputs SHALL hold and stall_err SHALL set to 1 until rst.
REQ-010 When stall_mem=0 and stall_wb=0 (capture), every wb_* output SHALL load its mem_* input.
REQ-011 In capture with mem_valid=0, every captured enable (wreg, whilo, llbit_we, cp0_we) SHALL be forced to 0; data fields SHALL still load.
REQ-012 Lane dedup in capture: if lanes i<j both have wreg=1 and equal wd, wb_wreg[i] SHALL be cleared, so the highest lane wins.
REQ-013 Lane dedup SHALL treat wd=0 like any other address; $zero suppression is the register file's job.
REQ-014 bubble_cnt SHALL increment by 1 on every edge where flush or bubble loads the bubble value, and SHALL saturate at all-ones.
REQ-015 cnt_clr=1 SHALL set bubble_cnt to 0 and SHALL take precedence over a simultaneous increment.
REQ-016 When flush and a stall are active together, the flush action SHALL apply and bubble_cnt SHALL increment once.

Reset
REQ-017 While rst=1 at a clk edge, every output SHALL become 0, including bubble_cnt and stall_err.
REQ-018 Reset SHALL override flush, stalls and cnt_clr; an instruction captured in the same cycle is discarded.
REQ-019 The first capture SHALL occur on the first edge with rst=0 and no stall or flush.

Structure
REQ-020 The shared defines file SHALL hold RstEnable, WriteDisable, ZeroWord, NOPRegAddr and the default DW/AW values; no new global defines SHALL be added.
REQ-021 One sub-module SHALL exist: wb_lane_reg, one instance per lane, holding wd/wreg/wdata with the hold/bubble/capture mux.
REQ-022 Dedup logic and the shared HI/LO/LL/CP0 fields SHALL reside in mem_wb_stage.
REQ-023 All sequential assignments SHALL be non-blocking.

Verification
REQ-024 Reset then capture, NCH=2: lane0 wd=3 wreg=1 wdata=0x1234, lane1 wd=7 wreg=1 wdata=0xABCD, mem_valid=1 -> one cycle later both lanes appear unchanged and wb_valid=1.
REQ-025 Hold then bubble: stall_mem=1 and stall_wb=1 for 3 cycles -> outputs unchanged; then stall_wb=0 -> next cycle all enables are 0 and bubble_cnt=1.
REQ-026 Dedup: both lanes wd=9 wreg=1 with wdata 0x11/0x22 -> wb_wreg=2'b10 and lane1 wdata=0x22.
REQ-027 Flush with hold: flush=1 with stall_mem=stall_wb=1 and whilo=1 -> wb_whilo=0, wb_valid=0, and bubble_cnt increments once.
REQ-028 Counter and illegal stall:
- CW=4 with 20 bubbles -> bubble_cnt=15.
- cnt_clr together with a bubble -> bubble_cnt=0.
- stall_mem=0, stall_wb=1 -> stall_err=1 and outputs held.
REQ-029 Invalid capture: mem_valid=0 with wreg=2'b11, cp0_we=1 -> all wb enables are 0 and wb_wdata equals the input.
